cpu_mc: RTL and testbench

Parametrised multi-cycle successor of the single-cycle core. It executes a MIPS-32 integer subset through a fetch/decode/execute/memory/writeback state machine. Instruction and data memories sit behind separate req/ack handshakes, so variable-latency ROM/RAM (including the synchronous on-chip ROM) is tolerated. It sits at the top of the CPU hierarchy, replacing the fixed 5-bit-address fetch path. It adds halt-on-fault behaviour and a parametrised debug register tap.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/cpu_alu.sv | 23 ++
 rtl/cpu_mc.sv | 170 +++++++++++++++++
 tb/tb_cpu_mc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-32 subset core: opcodes, functs,
// FSM state and ALU operation types, plus small decode helpers.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_IF    = 3'd1,
        ST_ID    = 3'd2,
        ST_EX    = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        ok = 1'b0;
        case (ins[31:26])
            OP_RTYPE: ok = (ins[5:0] == FN_ADDU) || (ins[5:0] == FN_SUBU) ||
                           (ins[5:0] == FN_AND)  || (ins[5:0] == FN_OR)   ||
                           (ins[5:0] == FN_SLT);
            OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU shared by R-type, addiu and load/store address generation.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle MIPS-32 subset core with req/ack instruction and data ports,
// halt-on-fault and a single-register debug tap on ans.
module cpu_mc
    import cpu_pkg::*;
#(
    parameter int unsigned IADDR_W  = 5,
    parameter int unsigned DADDR_W  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ANS_REG  = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic [31:0]        ans,
    output logic               halted
);

    localparam logic [4:0] ANS_IDX = 5'(ANS_REG);

    state_t      state;
    logic [31:0] rf [32];
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] result_q;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [31:0] imm_sext, pc_plus4, alu_b, alu_result;
    logic        rf_we;
    alu_op_t     alu_op;

    assign opcode    = inst[31:26];
    assign rs        = inst[25:21];
    assign rt        = inst[20:16];
    assign rd        = inst[15:11];
    assign imm_sext  = sext16(inst[15:0]);
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IADDR_W+1:2];
    assign wb_dest   = (opcode == OP_RTYPE) ? rd : rt;
    assign rf_we     = (state == ST_WB) && (wb_dest != 5'd0);
    assign alu_b     = (opcode == OP_RTYPE) ? rt_val : imm_sext;
    assign ans       = (ANS_IDX == 5'd0) ? '0 : rf[ANS_IDX];

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (inst[5:0])
                FN_SUBU: alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    cpu_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    // Register file is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rf_we) rf[wb_dest] <= result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_START;
            pc         <= RESET_PC;
            inst       <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            rs_val     <= '0;
            rt_val     <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                ST_START: begin
                    imem_req <= 1'b1;
                    state    <= ST_IF;
                end
                ST_IF: begin
                    if (imem_req && imem_ack) begin
                        inst     <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_ID;
                    end
                end
                ST_ID: begin
                    rs_val <= (rs == 5'd0) ? '0 : rf[rs];
                    rt_val <= (rt == 5'd0) ? '0 : rf[rt];
                    if (!is_legal(inst)) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state  <= ST_EX;
                    end
                end
                ST_EX: begin
                    result_q <= alu_result;
                    case (opcode)
                        OP_BEQ: begin
                            pc    <= (rs_val == rt_val) ?
                                     pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
                            state <= ST_START;
                        end
                        OP_J: begin
                            pc    <= {pc_plus4[31:28], inst[25:0], 2'b00};
                            state <= ST_START;
                        end
                        OP_LW, OP_SW: begin
                            if (alu_result[1:0] != 2'b00) begin
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end else begin
                                dmem_req   <= 1'b1;
                                dmem_we    <= (opcode == OP_SW);
                                dmem_addr  <= alu_result[DADDR_W+1:2];
                                dmem_wdata <= rt_val;
                                state      <= ST_MEM;
                            end
                        end
                        default: state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc    <= pc_plus4;
                            state <= ST_START;
                        end else begin
                            result_q <= dmem_rdata;
                            state    <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc    <= pc_plus4;
                    state <= ST_START;
                end
                ST_HALT: state <= ST_HALT;
                default: begin
                    halted <= 1'b1;
                    state  <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: an instruction-level reference model runs in
// lockstep with the core and is checked every cycle, plus literal spot checks.
module tb_cpu_mc;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [4:0]  imem_addr;
    logic [7:0]  dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, pc, inst, ans;

    always #5 clk = ~clk;

    cpu_mc #(
        .IADDR_W  (5),
        .DADDR_W  (8),
        .RESET_PC (RPC),
        .ANS_REG  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .inst       (inst),
        .ans        (ans),
        .halted     (halted)
    );

    // Memory responders with programmable wait states.
    logic [31:0] imem [32];
    logic [31:0] ram  [256];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc_cnt = 0;
    bit          stray_ack = 1'b0;

    assign imem_ack   = (imem_req && (icnt == iwait)) || stray_ack;
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dwait);
    assign dmem_rdata = ram[dmem_addr];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        icnt    <= (!imem_req || imem_ack) ? 0 : icnt + 1;
        dcnt    <= (!dmem_req || dmem_ack) ? 0 : dcnt + 1;
        if (dmem_req && dmem_we && dmem_ack) ram[dmem_addr] <= dmem_wdata;
    end

    // Reference model state
    logic [31:0] m_pc, m_inst, m_dwdata;
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [256];
    logic [7:0]  m_daddr;
    bit          m_halted, m_dvalid, m_dwe, boundary, checking;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("pc", pc, m_pc);
            chk("halted", {31'b0, halted}, {31'b0, m_halted});
            chk("ans", ans, m_regs[2]);
            if (boundary) chk("inst", inst, m_inst);
            if (imem_req) chk("imem_addr", {27'b0, imem_addr}, {27'b0, m_pc[6:2]});
            if (m_halted) chk("req_in_halt", {30'b0, imem_req, dmem_req}, 32'd0);
            if (dmem_req) begin
                chk("dmem_req_expected", {31'b0, m_dvalid}, 32'd1);
                chk("dmem_addr", {24'b0, dmem_addr}, {24'b0, m_daddr});
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_dwe});
                if (m_dwe) chk("dmem_wdata", dmem_wdata, m_dwdata);
            end
        end
    end

    // Executes one instruction at ISA level; architectural effects become
    // visible on the final edge of the instruction's cycle count.
    task automatic exec_one(input int skip);
        logic [31:0] ins, a, b, simm, ea, npc, wv;
        logic [5:0]  op, fn;
        logic [4:0]  wi;
        bit          wen, halt, st;
        int          cyc;
        ins  = imem[m_pc[6:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = m_pc + 32'd4;
        wi   = ins[15:11];
        wv   = '0;
        wen  = 1'b0;
        halt = 1'b0;
        st   = 1'b0;
        ea   = a + simm;
        cyc  = 5 + iwait;
        case (op)
            6'h00: begin
                wen = 1'b1;
                case (fn)
                    6'h21: wv = a + b;
                    6'h23: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin wen = 1'b0; halt = 1'b1; cyc = 3 + iwait; end
                endcase
            end
            6'h09: begin wen = 1'b1; wi = ins[20:16]; wv = a + simm; end
            6'h23, 6'h2B: begin
                if (ea[1:0] != 2'b00) begin
                    halt = 1'b1;
                    cyc  = 4 + iwait;
                end else begin
                    m_dvalid = 1'b1;
                    m_daddr  = ea[9:2];
                    m_dwe    = (op == 6'h2B);
                    m_dwdata = b;
                    if (op == 6'h23) begin
                        wen = 1'b1; wi = ins[20:16]; wv = m_dmem[ea[9:2]];
                        cyc = 6 + iwait + dwait;
                    end else begin
                        st  = 1'b1;
                        cyc = 5 + iwait + dwait;
                    end
                end
            end
            6'h04: begin
                cyc = 4 + iwait;
                if (a == b) npc = m_pc + 32'd4 + (simm << 2);
            end
            6'h02: begin
                cyc = 4 + iwait;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: begin halt = 1'b1; cyc = 3 + iwait; end
        endcase
        if (halt) npc = m_pc;
        repeat (cyc - skip) begin
            @(posedge clk);
            boundary = 1'b0;
        end
        m_pc = npc;
        if (wen && wi != 5'd0) m_regs[wi] = wv;
        if (st) m_dmem[ea[9:2]] = b;
        m_halted = halt;
        m_inst   = ins;
        m_dvalid = 1'b0;
        boundary = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        m_pc     = RPC;
        m_inst   = '0;
        m_halted = 1'b0;
        m_dvalid = 1'b0;
        boundary = 1'b1;
        checking = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic idle_check(input string name);
        int reqs;
        reqs = 0;
        repeat (20) begin
            @(posedge clk);
            boundary = 1'b0;
            #1 if (imem_req || dmem_req) reqs++;
        end
        chk(name, 32'(reqs), 32'd0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 256; i++) begin ram[i] = '0; m_dmem[i] = '0; end
        for (int i = 0; i < 32; i++)  begin imem[i] = '0; m_regs[i] = '0; end
        checking = 1'b0;

        // Program A: arithmetic, store/load with slow data memory, branch, jump
        imem[16] = 32'h24020005;  imem[17] = 32'h2403FFF9;
        imem[18] = 32'h00431021;  imem[19] = 32'h0062202A;
        imem[20] = 32'hAC020008;  imem[21] = 32'h8C050008;
        imem[22] = 32'h00A41023;  imem[23] = 32'h00641025;
        imem[24] = 32'h0083102A;  imem[25] = 32'h00A41024;
        imem[26] = 32'h24000007;  imem[27] = 32'h00801021;
        imem[28] = 32'h10400005;  imem[29] = 32'h08000010;
        iwait = 0; dwait = 3;
        do_reset();
        t0 = cyc_cnt;
        chk("rst_pc", pc, 32'h40);
        chk("rst_inst", inst, 32'h0);
        chk("rst_ireq", {31'b0, imem_req}, 32'd0);
        chk("rst_dreq", {31'b0, dmem_req}, 32'd0);
        chk("rst_dwe", {31'b0, dmem_we}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        @(posedge clk); boundary = 1'b0;
        #1 chk("first_ireq", {31'b0, imem_req}, 32'd1);
        chk("first_iaddr", {27'b0, imem_addr}, 32'h10);
        exec_one(1); exec_one(0); exec_one(0);
        #1 chk("ans_addu", ans, 32'hFFFFFFFE);
        chk("cycles_3", 32'(cyc_cnt - t0), 32'd15);
        exec_one(0); exec_one(0);
        #1 chk("ram_sw", ram[2], 32'hFFFFFFFE);
        t0 = cyc_cnt;
        exec_one(0);
        #1 chk("lw_cycles", 32'(cyc_cnt - t0), 32'd9);
        exec_one(0);
        #1 chk("ans_subu", ans, 32'hFFFFFFFD);
        exec_one(0); exec_one(0);
        #1 chk("ans_slt_signed", ans, 32'h0);
        exec_one(0); exec_one(0); exec_one(0);
        #1 chk("ans_r0_discard", ans, 32'h1);
        exec_one(0);
        #1 chk("beq_not_taken", pc, 32'h74);
        exec_one(0);
        #1 chk("j_target", pc, 32'h40);
        exec_one(0);
        #1 chk("ans_after_j", ans, 32'h5);

        // Program B: taken forward beq, then beq -1 self-loop
        imem[16] = 32'h10000001; imem[17] = 32'hFC000000; imem[18] = 32'h1000FFFF;
        iwait = 1; dwait = 0;
        do_reset();
        exec_one(0);
        #1 chk("beq_fwd", pc, 32'h48);
        exec_one(0); exec_one(0);
        #1 chk("beq_loop", pc, 32'h48);

        // Program C: illegal opcode
        imem[16] = 32'hFC000000;
        iwait = 0;
        do_reset();
        exec_one(0);
        #1 chk("halt_illegal", {31'b0, halted}, 32'd1);
        chk("pc_illegal", pc, 32'h40);
        idle_check("reqs_after_illegal");

        // Program D: misaligned load
        imem[16] = 32'h24060003; imem[17] = 32'h8CC70000;
        do_reset();
        exec_one(0); exec_one(0);
        #1 chk("halt_misaligned", {31'b0, halted}, 32'd1);
        chk("pc_misaligned", pc, 32'h44);
        idle_check("reqs_after_misaligned");

        // Program E: reset while a slow fetch is outstanding, then a stray ack
        imem[16] = 32'h24020005;
        iwait = 5;
        do_reset();
        @(posedge clk); boundary = 1'b0;
        #1 chk("e_ireq_up", {31'b0, imem_req}, 32'd1);
        @(posedge clk); boundary = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("e_req_dropped", {31'b0, imem_req}, 32'd0);
        chk("e_pc_reset", pc, 32'h40);
        rst = 1'b0;
        stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        chk("e_inst_kept", inst, 32'h0);
        exec_one(1);
        #1 chk("e_ans", ans, 32'h5);
        chk("e_pc", pc, 32'h44);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
